// File: rtl/dcache_mshr.sv
// Miss status holding registers for the dcache load pipe: tracks line misses,
// issues one refill request per entry, buffers the returned line and wakes the load.
`ifndef PADDR_RANGE
`define PADDR_RANGE 31:0
`endif
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif

module dcache_mshr #(
  parameter int unsigned MSHR_NUM      = 4,
  parameter int unsigned MSHR_ID_WIDTH = 2,
  parameter int unsigned LINE_WIDTH    = 512
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     mshr_allocate_valid,
  output logic                     mshr_allocate_ready,
  input  logic [`PADDR_RANGE]      mshr_allocate_paddr,
  input  logic [`ROB_SIZE_LOG:0]   mshr_allocate_robid,
  output logic                     bus_req_valid,
  input  logic                     bus_req_ready,
  output logic [`PADDR_RANGE]      bus_req_paddr,
  output logic [MSHR_ID_WIDTH-1:0] bus_req_id,
  input  logic                     bus_resp_valid,
  input  logic [MSHR_ID_WIDTH-1:0] bus_resp_id,
  input  logic [LINE_WIDTH-1:0]    bus_resp_data,
  output logic                     refill_valid,
  input  logic                     refill_ready,
  output logic [`PADDR_RANGE]      refill_paddr,
  output logic [LINE_WIDTH-1:0]    refill_data,
  output logic                     wakeup_valid,
  output logic [`ROB_SIZE_LOG:0]   wakeup_robid,
  output logic                     mshr_full
);

  typedef logic [`PADDR_RANGE]    paddr_t;
  typedef logic [`ROB_SIZE_LOG:0] robid_t;
  typedef logic [MSHR_ID_WIDTH-1:0] idx_t;
  typedef enum logic [1:0] {FREE, PEND, WAIT, REFILL} ent_state_e;

  localparam int unsigned PA_W      = $bits(paddr_t);
  localparam paddr_t      LINE_MASK = ~paddr_t'(6'h3f);

  ent_state_e             state_q [MSHR_NUM];
  logic [MSHR_NUM-1:0]    killed_q;
  paddr_t                 paddr_q [MSHR_NUM];
  robid_t                 robid_q [MSHR_NUM];
  logic [LINE_WIDTH-1:0]  data_q  [MSHR_NUM];
  logic                   req_lock_q;
  idx_t                   req_sel_q;

  logic any_free, any_pend, any_refill, dup_line;
  idx_t free_idx, pend_idx, refill_idx, req_idx;
  logic alloc_fire, req_fire, resp_hit, refill_fire;

  always_comb begin
    any_free   = 1'b0;
    any_pend   = 1'b0;
    any_refill = 1'b0;
    dup_line   = 1'b0;
    free_idx   = '0;
    pend_idx   = '0;
    refill_idx = '0;
    for (int unsigned i = 0; i < MSHR_NUM; i++) begin
      if (state_q[i] == FREE && !any_free) begin
        any_free = 1'b1;
        free_idx = idx_t'(i);
      end
      if (state_q[i] == PEND && !any_pend) begin
        any_pend = 1'b1;
        pend_idx = idx_t'(i);
      end
      if (state_q[i] == REFILL && !any_refill) begin
        any_refill = 1'b1;
        refill_idx = idx_t'(i);
      end
      if (state_q[i] != FREE && paddr_q[i][PA_W-1:6] == mshr_allocate_paddr[PA_W-1:6])
        dup_line = 1'b1;
    end
  end

  assign mshr_full           = !any_free;
  assign mshr_allocate_ready = !flush && any_free && !dup_line;
  assign alloc_fire          = mshr_allocate_valid && mshr_allocate_ready;

  // Once presented, the request stays on the latched entry until it fires.
  assign req_idx       = req_lock_q ? req_sel_q : pend_idx;
  assign bus_req_valid = any_pend && !flush;
  assign bus_req_id    = bus_req_valid ? req_idx : '0;
  assign bus_req_paddr = bus_req_valid ? paddr_q[req_idx] : '0;
  assign req_fire      = bus_req_valid && bus_req_ready;

  assign resp_hit = bus_resp_valid && state_q[bus_resp_id] == WAIT;

  assign refill_valid = any_refill;
  assign refill_paddr = any_refill ? paddr_q[refill_idx] : '0;
  assign refill_data  = any_refill ? data_q[refill_idx] : '0;
  assign refill_fire  = refill_valid && refill_ready;
  assign wakeup_valid = refill_fire && !killed_q[refill_idx] && !flush;
  assign wakeup_robid = wakeup_valid ? robid_q[refill_idx] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MSHR_NUM; i++) state_q[i] <= FREE;
      killed_q   <= '0;
      req_lock_q <= 1'b0;
      req_sel_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < MSHR_NUM; i++) begin
        case (state_q[i])
          FREE: if (alloc_fire && free_idx == idx_t'(i)) begin
            state_q[i]  <= PEND;
            killed_q[i] <= 1'b0;
          end
          PEND: begin
            if (flush) state_q[i] <= FREE;
            else if (req_fire && req_idx == idx_t'(i)) state_q[i] <= WAIT;
          end
          WAIT: begin
            if (resp_hit && bus_resp_id == idx_t'(i)) state_q[i] <= REFILL;
            if (flush) killed_q[i] <= 1'b1;
          end
          REFILL: begin
            if (refill_fire && refill_idx == idx_t'(i)) state_q[i] <= FREE;
            if (flush) killed_q[i] <= 1'b1;
          end
          default: state_q[i] <= FREE;
        endcase
      end
      if (flush || req_fire) begin
        req_lock_q <= 1'b0;
      end else if (bus_req_valid) begin
        req_lock_q <= 1'b1;
        req_sel_q  <= req_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      paddr_q[free_idx] <= mshr_allocate_paddr & LINE_MASK;
      robid_q[free_idx] <= mshr_allocate_robid;
    end
    if (resp_hit) data_q[bus_resp_id] <= bus_resp_data;
  end

  resp_on_wait_entry: assert property (@(posedge clock) disable iff (!reset_n)
    bus_resp_valid |-> resp_hit);

endmodule

// File: tb/tb_dcache_mshr.sv
// Self-checking bench for dcache_mshr: directed scenarios plus randomized traffic
// compared every cycle against an entry-list reference model.
module tb_dcache_mshr;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned LW  = 512;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           flush;
  logic           mshr_allocate_valid;
  logic           mshr_allocate_ready;
  logic [31:0]    mshr_allocate_paddr;
  logic [6:0]     mshr_allocate_robid;
  logic           bus_req_valid;
  logic           bus_req_ready;
  logic [31:0]    bus_req_paddr;
  logic [IDW-1:0] bus_req_id;
  logic           bus_resp_valid;
  logic [IDW-1:0] bus_resp_id;
  logic [LW-1:0]  bus_resp_data;
  logic           refill_valid;
  logic           refill_ready;
  logic [31:0]    refill_paddr;
  logic [LW-1:0]  refill_data;
  logic           wakeup_valid;
  logic [6:0]     wakeup_robid;
  logic           mshr_full;

  always #5 clock = ~clock;

  dcache_mshr #(.MSHR_NUM(N), .MSHR_ID_WIDTH(IDW), .LINE_WIDTH(LW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .mshr_allocate_valid(mshr_allocate_valid), .mshr_allocate_ready(mshr_allocate_ready),
    .mshr_allocate_paddr(mshr_allocate_paddr), .mshr_allocate_robid(mshr_allocate_robid),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_paddr(bus_req_paddr), .bus_req_id(bus_req_id),
    .bus_resp_valid(bus_resp_valid), .bus_resp_id(bus_resp_id), .bus_resp_data(bus_resp_data),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_paddr(refill_paddr), .refill_data(refill_data),
    .wakeup_valid(wakeup_valid), .wakeup_robid(wakeup_robid), .mshr_full(mshr_full)
  );

  int checks = 0;
  int failures = 0;

  // Model: each slot is an outstanding miss described by what has happened to it so far.
  typedef struct {
    bit          busy;
    bit          requested;
    bit          has_data;
    bit          killed;
    logic [31:0] line;
    logic [6:0]  robid;
    logic [LW-1:0] data;
  } ent_t;
  ent_t m [N];
  bit   m_lock;
  int   m_lock_id;

  int   p_free, p_rf, p_req;
  logic e_ready, e_full, e_rv, e_fv, e_wv;
  logic [IDW-1:0] e_rid;
  logic [31:0] e_rpaddr, e_fpaddr;
  logic [LW-1:0] e_fdata;
  logic [6:0] e_wrob;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m[i].busy = 0; m[i].requested = 0; m[i].has_data = 0; m[i].killed = 0;
      m[i].line = '0; m[i].robid = '0; m[i].data = '0;
    end
    m_lock = 0;
    m_lock_id = 0;
  endtask

  task automatic predict();
    int pend = -1;
    bit dup = 0;
    p_free = -1;
    p_rf = -1;
    for (int i = 0; i < N; i++) begin
      if (!m[i].busy) begin
        if (p_free < 0) p_free = i;
      end else if (m[i].line[31:6] == mshr_allocate_paddr[31:6]) dup = 1;
      if (m[i].busy && !m[i].requested && pend < 0) pend = i;
      if (m[i].has_data && p_rf < 0) p_rf = i;
    end
    e_full  = (p_free < 0);
    e_ready = !flush && (p_free >= 0) && !dup;
    e_rv    = !flush && (pend >= 0);
    p_req   = m_lock ? m_lock_id : pend;
    e_rid    = e_rv ? IDW'(p_req) : '0;
    e_rpaddr = e_rv ? m[p_req].line : '0;
    e_fv     = (p_rf >= 0);
    e_fpaddr = e_fv ? m[p_rf].line : '0;
    e_fdata  = e_fv ? m[p_rf].data : '0;
    e_wv     = e_fv && refill_ready && !m[p_rf].killed && !flush;
    e_wrob   = e_wv ? m[p_rf].robid : '0;
  endtask

  task automatic compare_all();
    chk("alloc_ready", LW'(mshr_allocate_ready), LW'(e_ready));
    chk("mshr_full", LW'(mshr_full), LW'(e_full));
    chk("bus_req_valid", LW'(bus_req_valid), LW'(e_rv));
    chk("bus_req_id", LW'(bus_req_id), LW'(e_rid));
    chk("bus_req_paddr", LW'(bus_req_paddr), LW'(e_rpaddr));
    chk("refill_valid", LW'(refill_valid), LW'(e_fv));
    chk("refill_paddr", LW'(refill_paddr), LW'(e_fpaddr));
    chk("refill_data", refill_data, e_fdata);
    chk("wakeup_valid", LW'(wakeup_valid), LW'(e_wv));
    chk("wakeup_robid", LW'(wakeup_robid), LW'(e_wrob));
  endtask

  task automatic advance();
    bit afire = mshr_allocate_valid && e_ready;
    bit qfire = e_rv && bus_req_ready;
    if (e_fv && refill_ready) begin
      m[p_rf].busy = 0; m[p_rf].requested = 0; m[p_rf].has_data = 0; m[p_rf].killed = 0;
    end
    if (bus_resp_valid && m[bus_resp_id].requested && !m[bus_resp_id].has_data) begin
      m[bus_resp_id].has_data = 1;
      m[bus_resp_id].data = bus_resp_data;
    end
    if (flush)
      for (int i = 0; i < N; i++) begin
        if (m[i].busy && !m[i].requested) m[i].busy = 0;
        else if (m[i].busy) m[i].killed = 1;
      end
    if (qfire) m[p_req].requested = 1;
    if (afire) begin
      m[p_free].busy = 1; m[p_free].requested = 0; m[p_free].has_data = 0; m[p_free].killed = 0;
      m[p_free].line = mshr_allocate_paddr & ~32'h3f;
      m[p_free].robid = mshr_allocate_robid;
    end
    if (flush || qfire) m_lock = 0;
    else if (e_rv) begin m_lock = 1; m_lock_id = p_req; end
  endtask

  task automatic idle();
    flush = 0; mshr_allocate_valid = 0; mshr_allocate_paddr = '0; mshr_allocate_robid = '0;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_id = '0; bus_resp_data = '0;
    refill_ready = 0;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic fin();
    predict();
    compare_all();
    advance();
    @(posedge clock);
    #1;
  endtask

  task automatic alloc(input logic [31:0] pa, input logic [6:0] rob);
    mshr_allocate_valid = 1; mshr_allocate_paddr = pa; mshr_allocate_robid = rob;
  endtask

  function automatic int pick_waiting();
    int n = 0;
    int ids [N];
    for (int i = 0; i < N; i++)
      if (m[i].busy && m[i].requested && !m[i].has_data) begin ids[n] = i; n++; end
    return (n == 0) ? -1 : ids[$urandom_range(0, n - 1)];
  endfunction

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      int w;
      idle();
      bus_req_ready = 1;
      refill_ready = 1;
      w = pick_waiting();
      if (w >= 0) begin bus_resp_valid = 1; bus_resp_id = IDW'(w); bus_resp_data = rand_line(); end
      settle();
      fin();
    end
    settle();
    chk("drain_full", LW'(mshr_full), LW'(0));
    chk("drain_refill_valid", LW'(refill_valid), LW'(0));
    chk("drain_req_valid", LW'(bus_req_valid), LW'(0));
    fin();
  endtask

  initial begin
    logic [LW-1:0] da, db;
    idle();
    clear_model();
    reset_n = 0;
    #12;
    predict();
    compare_all();
    chk("rst_alloc_ready", LW'(mshr_allocate_ready), LW'(1));
    chk("rst_full", LW'(mshr_full), LW'(0));
    chk("rst_req_valid", LW'(bus_req_valid), LW'(0));
    #2 reset_n = 1;
    @(posedge clock); #1;

    // Single miss end to end
    idle(); alloc(32'h12345678, 7'd5); bus_req_ready = 1;
    settle(); chk("a_ready", LW'(mshr_allocate_ready), LW'(1)); fin();
    idle(); bus_req_ready = 1;
    settle();
    chk("a_req_valid", LW'(bus_req_valid), LW'(1));
    chk("a_req_paddr", LW'(bus_req_paddr), LW'(32'h12345640));
    chk("a_req_id", LW'(bus_req_id), LW'(0));
    fin();
    idle(); bus_resp_valid = 1; bus_resp_id = 0; bus_resp_data = {64{8'hA5}};
    settle(); chk("a_req_dropped", LW'(bus_req_valid), LW'(0)); fin();
    idle(); refill_ready = 1;
    settle();
    chk("a_refill_valid", LW'(refill_valid), LW'(1));
    chk("a_refill_data", refill_data, {64{8'hA5}});
    chk("a_wakeup_valid", LW'(wakeup_valid), LW'(1));
    chk("a_wakeup_robid", LW'(wakeup_robid), LW'(5));
    fin();
    idle(); settle();
    chk("a_refill_done", LW'(refill_valid), LW'(0));
    chk("a_not_full", LW'(mshr_full), LW'(0));
    fin();

    // Fill all entries, then free entry 2 and reuse it
    for (int k = 0; k < 4; k++) begin
      idle(); alloc(32'h1000 * (k + 1), 7'(10 + k));
      settle(); chk("b_fill_ready", LW'(mshr_allocate_ready), LW'(1)); fin();
    end
    idle(); alloc(32'h5000, 7'd14);
    settle();
    chk("b_full", LW'(mshr_full), LW'(1));
    chk("b_full_ready", LW'(mshr_allocate_ready), LW'(0));
    fin();
    for (int k = 0; k < 4; k++) begin
      idle(); bus_req_ready = 1;
      settle(); chk("b_req_order", LW'(bus_req_id), LW'(k)); fin();
    end
    idle(); bus_resp_valid = 1; bus_resp_id = 2; bus_resp_data = rand_line();
    settle(); fin();
    idle(); refill_ready = 1; alloc(32'h5000, 7'd14);
    settle();
    chk("b_refill_cycle_ready", LW'(mshr_allocate_ready), LW'(0));
    chk("b_refill_paddr", LW'(refill_paddr), LW'(32'h3000));
    fin();
    idle(); alloc(32'h5000, 7'd14);
    settle(); chk("b_reuse_ready", LW'(mshr_allocate_ready), LW'(1)); fin();
    idle(); settle();
    chk("b_reuse_id", LW'(bus_req_id), LW'(2));
    chk("b_reuse_paddr", LW'(bus_req_paddr), LW'(32'h5000));
    fin();
    drain();

    // Duplicate line blocking
    idle(); alloc(32'h1000, 7'd1); settle(); fin();
    idle(); alloc(32'h1020, 7'd2); settle(); chk("c_dup_ready", LW'(mshr_allocate_ready), LW'(0)); fin();
    idle(); alloc(32'h2000, 7'd3); settle(); chk("c_new_ready", LW'(mshr_allocate_ready), LW'(1)); fin();
    drain();

    // Sticky request selection
    idle(); alloc(32'h1000, 7'd1); settle(); fin();
    idle(); bus_req_ready = 1; settle(); fin();
    idle(); alloc(32'h2000, 7'd2); bus_resp_valid = 1; bus_resp_id = 0; bus_resp_data = rand_line();
    settle(); fin();
    idle(); refill_ready = 1; settle(); chk("d_present_id", LW'(bus_req_id), LW'(1)); fin();
    idle(); alloc(32'h3000, 7'd3); settle(); chk("d_hold_id_a", LW'(bus_req_id), LW'(1)); fin();
    idle(); bus_req_ready = 1; settle(); chk("d_hold_id_b", LW'(bus_req_id), LW'(1)); fin();
    idle(); settle();
    chk("d_next_valid", LW'(bus_req_valid), LW'(1));
    chk("d_next_id", LW'(bus_req_id), LW'(0));
    fin();
    drain();

    // Flush with one WAIT and one PEND entry
    idle(); alloc(32'h1000, 7'd9); settle(); fin();
    idle(); bus_req_ready = 1; settle(); fin();
    idle(); alloc(32'h2000, 7'd8); settle(); fin();
    idle(); flush = 1; alloc(32'h3000, 7'd7); bus_req_ready = 1;
    settle();
    chk("e_flush_req", LW'(bus_req_valid), LW'(0));
    chk("e_flush_ready", LW'(mshr_allocate_ready), LW'(0));
    fin();
    idle(); bus_resp_valid = 1; bus_resp_id = 0; bus_resp_data = rand_line();
    settle(); chk("e_pend_gone", LW'(bus_req_valid), LW'(0)); fin();
    idle(); refill_ready = 1;
    settle();
    chk("e_refill_valid", LW'(refill_valid), LW'(1));
    chk("e_refill_paddr", LW'(refill_paddr), LW'(32'h1000));
    chk("e_no_wakeup", LW'(wakeup_valid), LW'(0));
    fin();
    drain();

    // Out-of-order responses, refill in index order
    for (int k = 0; k < 6; k++) begin
      idle(); bus_req_ready = 1;
      if (k < 4) alloc(32'h8000 + 32'h40 * k, 7'(20 + k));
      settle(); fin();
    end
    da = rand_line();
    db = rand_line();
    idle(); bus_resp_valid = 1; bus_resp_id = 3; bus_resp_data = da; settle(); fin();
    idle(); bus_resp_valid = 1; bus_resp_id = 1; bus_resp_data = db; settle(); fin();
    idle(); refill_ready = 1;
    settle();
    chk("f_first_paddr", LW'(refill_paddr), LW'(32'h8040));
    chk("f_first_data", refill_data, db);
    chk("f_first_robid", LW'(wakeup_robid), LW'(21));
    fin();
    idle(); refill_ready = 1;
    settle();
    chk("f_second_paddr", LW'(refill_paddr), LW'(32'h80C0));
    chk("f_second_data", refill_data, da);
    chk("f_second_robid", LW'(wakeup_robid), LW'(23));
    fin();
    drain();

    // Randomized traffic over a small set of lines to provoke duplicates
    for (int c = 0; c < 800; c++) begin
      int w;
      idle();
      if ($urandom_range(0, 1) == 1)
        alloc({23'h40 + 23'($urandom_range(0, 7)), 3'($urandom), 6'($urandom)}, 7'($urandom));
      bus_req_ready = ($urandom_range(0, 3) != 0);
      refill_ready  = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      w = pick_waiting();
      if (w >= 0 && $urandom_range(0, 1) == 1) begin
        bus_resp_valid = 1; bus_resp_id = IDW'(w); bus_resp_data = rand_line();
      end
      settle();
      fin();
    end

    // Asynchronous reset in the middle of activity
    idle(); alloc(32'h9000, 7'd4); bus_req_ready = 1; settle(); fin();
    idle();
    #2 reset_n = 0;
    #1;
    clear_model();
    predict();
    compare_all();
    chk("async_rst_full", LW'(mshr_full), LW'(0));
    chk("async_rst_req", LW'(bus_req_valid), LW'(0));
    @(negedge clock);
    #2 reset_n = 1;
    @(posedge clock); #1;
    idle(); alloc(32'h9000, 7'd6); settle(); chk("post_rst_ready", LW'(mshr_allocate_ready), LW'(1)); fin();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_mshr.md
Name: dcache_mshr

Overview:
- Miss status holding register file directly downstream of the dcache load-pipe lookup stage.
- Accepts miss allocations (line paddr plus ROB id), issues one line-refill request per entry to the L2/bus side, and buffers the 512-bit refill response.
- Hands each refilled line to the dcache refill write port and wakes up the originating load by ROB id.
- Flush kills outstanding wakeups without corrupting the cache.

Parameters:
- MSHR_NUM, 4, number of entries; power of 2, at least 2.
- MSHR_ID_WIDTH, 2, log2(MSHR_NUM); width of request and response ids.
- LINE_WIDTH, 512, refill line width in bits (64B line, offset bits [5:0]).

Ports:
- clock  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush; kills pending wakeups.
- mshr_allocate_valid  input  1  miss allocation request.
- mshr_allocate_ready  output  1  entry available and no duplicate line.
- mshr_allocate_paddr  input  `PADDR_RANGE  miss physical address.
- mshr_allocate_robid  input  `ROB_SIZE_LOG+1  ROB id of the missing load.
- bus_req_valid  output  1  refill request valid.
- bus_req_ready  input  1  refill request accepted.
- bus_req_paddr  output  `PADDR_RANGE  line-aligned address; bits [5:0] are zero.
- bus_req_id  output  MSHR_ID_WIDTH  entry index.
- bus_resp_valid  input  1  refill data valid; there is no ready, it is always accepted.
- bus_resp_id  input  MSHR_ID_WIDTH  entry index being answered.
- bus_resp_data  input  LINE_WIDTH  line data.
- refill_valid  output  1  line ready for the cache write.
- refill_ready  input  1  cache write port granted.
- refill_paddr  output  `PADDR_RANGE  line-aligned address.
- refill_data  output  LINE_WIDTH  line data.
- wakeup_valid  output  1  load wakeup.
- wakeup_robid  output  `ROB_SIZE_LOG+1  ROB id to wake.
- mshr_full  output  1  no FREE entry.

Behaviour:
- Per-entry state:
  - FREE -> PEND on allocation.
  - PEND -> WAIT on bus request fire.
  - WAIT -> REFILL on matching response.
  - REFILL -> FREE on refill fire.
- Per-entry storage: line paddr (bits [5:0] cleared), robid, killed bit, line buffer.
- Reset: all entries FREE, killed=0, sticky request select cleared. All outputs 0 except mshr_allocate_ready=1 and mshr_full=0.
- Allocation:
  - mshr_allocate_ready = !flush & (some FREE entry) & (no non-FREE entry whose line address paddr[high:6] equals mshr_allocate_paddr[high:6]).
  - Readiness is computed combinationally from registered state plus the incoming paddr.
  - A fire (valid&ready) writes the lowest-index FREE entry; that entry is PEND from the next cycle, with killed=0.
  - An entry freed in cycle N is allocatable in cycle N+1, not in N.
- Bus request:
  - bus_req_valid = any PEND entry.
  - Selection is the lowest-index PEND entry, latched once presented: id and paddr stay stable until fire, even if a lower-index entry becomes PEND.
  - Exception: flush clears PEND entries, so bus_req_valid may drop without a fire.
  - On fire the entry moves to WAIT the next cycle and the latch is released. Back-to-back fires on consecutive cycles must be supported.
- Response:
  - bus_resp_valid with bus_resp_id on a WAIT entry captures the data into that entry and moves it to REFILL next cycle.
  - A response to a non-WAIT entry is ignored and flagged by an assertion.
- Refill:
  - refill_valid = any REFILL entry; lowest index wins.
  - refill_paddr and refill_data come from the selected entry. Not sticky; refill_ready is a same-cycle grant.
  - On fire the entry goes FREE next cycle.
  - wakeup_valid = refill fire & !killed & !flush (same cycle); wakeup_robid is the entry robid, and is 0 when wakeup_valid=0.
- Flush, in the flush cycle:
  - PEND entries -> FREE; no request is issued.
  - WAIT and REFILL entries set killed=1. They still complete and refill the cache, but never wake up.
  - An allocation in the flush cycle is blocked, because ready is 0.
- Simultaneous events:
  - A response arriving in the same cycle as a flush for a WAIT entry: data is captured, killed=1.
  - Allocation, request fire, response and refill fire on different entries in the same cycle are all honoured.
- mshr_full is registered-state based: 1 when no entry is FREE.
- Asynchronous reset mid-operation drops all entries immediately. Outstanding bus responses after reset are ignored per the response rule.

Test Plan:
- Reset, allocate paddr 0x12345678 robid 5, bus_req_ready=1 -> bus_req_paddr=0x12345640, id=0, next cycle bus_req_valid=0. Then resp id=0 data=0xA5.. -> refill_valid next cycle; refill_ready=1 -> wakeup_valid=1, robid=5, entry FREE.
- Allocate 4 distinct lines with bus_req_ready=0 -> mshr_full=1 and mshr_allocate_ready=0 on the 5th. Refill entry 2 -> ready=1 on the following cycle, new allocation lands in entry 2.
- Entry 0 pending line 0x1000, allocate 0x1020 -> ready=0 (duplicate line). Allocate 0x2000 -> ready=1.
- bus_req_ready=0 with entry 1 presented; free entry 0 and reallocate it -> bus_req_id stays 1 until fire, then 0.
- Entries 0 (WAIT) and 1 (PEND), assert flush -> entry 1 FREE with no request. Response id=0 -> refill_valid=1, wakeup_valid=0.
- Responses for ids 3 and 1 in consecutive cycles with refill_ready=1 -> refill order is id 1 (if both in REFILL), then 3, with correct data and robids.
